// File: rtl/led_mode_scheduler_if.sv
// Button-pulse inputs and LED/status outputs of the LED mode scheduler.
interface led_mode_scheduler_if;
  logic       btn_mode;
  logic       btn_faster;
  logic       btn_slower;
  logic       btn_pause;
  logic [3:0] led_out;
  logic [1:0] mode;
  logic [2:0] speed_lvl;
  logic       paused;
  logic       step_strobe;

  modport master (
    output btn_mode, btn_faster, btn_slower, btn_pause,
    input  led_out, mode, speed_lvl, paused, step_strobe
  );

  modport slave (
    input  btn_mode, btn_faster, btn_slower, btn_pause,
    output led_out, mode, speed_lvl, paused, step_strobe
  );
endinterface

// File: rtl/led_mode_scheduler.sv
// Running-light sequencer: button pulses select mode, speed and pause; a
// prescaler plus step counter set the step rate of the 4-bit LED pattern.
module led_mode_scheduler #(
  parameter int BASE_DIV   = 25,
  parameter int INIT_SPEED = 3
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  led_mode_scheduler_if.slave  bus
);

  // state   | meaning
  // SHIFT_L | rotate left from 0001
  // SHIFT_R | rotate right from 1000
  // BOUNCE  | ping-pong 0001..1000
  // BLINK   | invert 1111/0000
  localparam logic [1:0] SHIFT_L = 2'd0;
  localparam logic [1:0] SHIFT_R = 2'd1;
  localparam logic [1:0] BOUNCE  = 2'd2;
  localparam logic [1:0] BLINK   = 2'd3;

  localparam int               PRE_W   = $clog2(BASE_DIV);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(BASE_DIV - 1);

  logic [PRE_W-1:0] pre;
  logic [2:0]       stp;
  logic             dir_up;
  logic [3:0]       led_q;
  logic [1:0]       mode_q;
  logic [2:0]       speed_q;
  logic             paused_q;
  logic             strobe_q;

  logic [2:0]       speed_nxt;
  logic             speed_chg;
  logic             base_tick;
  logic             step_due;
  logic [3:0]       step_led;
  logic             step_dir_up;
  logic [1:0]       mode_nxt;

  function automatic logic [3:0] reload_pat(input logic [1:0] m);
    case (m)
      SHIFT_R: reload_pat = 4'b1000;
      BLINK:   reload_pat = 4'b1111;
      default: reload_pat = 4'b0001;
    endcase
  endfunction

  // Opposing or saturated presses leave speed_nxt equal to speed_q.
  always_comb begin
    speed_nxt = speed_q;
    if (bus.btn_faster && !bus.btn_slower && speed_q != 3'd0)
      speed_nxt = speed_q - 3'd1;
    else if (bus.btn_slower && !bus.btn_faster && speed_q != 3'd7)
      speed_nxt = speed_q + 3'd1;
  end

  assign speed_chg = (speed_nxt != speed_q);
  assign base_tick = (pre == PRE_MAX) && !paused_q;
  assign step_due  = base_tick && (stp == speed_q);
  assign mode_nxt  = mode_q + 2'd1;

  always_comb begin
    step_led    = led_q;
    step_dir_up = dir_up;
    case (mode_q)
      SHIFT_L: step_led = {led_q[2:0], led_q[3]};
      SHIFT_R: step_led = {led_q[0], led_q[3:1]};
      BOUNCE: begin
        if (dir_up) begin
          step_led = {led_q[2:0], 1'b0};
          if (step_led == 4'b1000) step_dir_up = 1'b0;
        end else begin
          step_led = {1'b0, led_q[3:1]};
          if (step_led == 4'b0001) step_dir_up = 1'b1;
        end
      end
      default: step_led = ~led_q;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      pre      <= '0;
      stp      <= '0;
      dir_up   <= 1'b1;
      led_q    <= 4'b0001;
      mode_q   <= SHIFT_L;
      speed_q  <= 3'(INIT_SPEED);
      paused_q <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      paused_q <= paused_q ^ bus.btn_pause;
      speed_q  <= speed_nxt;
      if (bus.btn_mode) begin
        mode_q <= mode_nxt;
        led_q  <= reload_pat(mode_nxt);
        dir_up <= 1'b1;
        pre    <= '0;
        stp    <= '0;
      end else if (speed_chg) begin
        pre <= '0;
        stp <= '0;
      end else if (!paused_q) begin
        if (base_tick) begin
          pre <= '0;
          if (step_due) begin
            stp      <= '0;
            led_q    <= step_led;
            dir_up   <= step_dir_up;
            strobe_q <= 1'b1;
          end else begin
            stp <= stp + 3'd1;
          end
        end else begin
          pre <= pre + 1'b1;
        end
      end
    end
  end

  assign bus.led_out     = led_q;
  assign bus.mode        = mode_q;
  assign bus.speed_lvl   = speed_q;
  assign bus.paused      = paused_q;
  assign bus.step_strobe = strobe_q;

endmodule

// File: tb/tb_led_mode_scheduler.sv
// Directed bench for led_mode_scheduler with BASE_DIV=4, INIT_SPEED=3.
module tb_led_mode_scheduler;
  localparam int BASE_DIV   = 4;
  localparam int INIT_SPEED = 3;

  typedef struct {
    logic       md, fa, sl, pa;
    logic [3:0] led;
    logic [1:0] mode;
    logic [2:0] spd;
    logic       paused;
    logic       strobe;
  } vec_t;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  int   errors  = 0;
  int   checks  = 0;
  vec_t tbl[$];

  led_mode_scheduler_if bus();

  led_mode_scheduler #(.BASE_DIV(BASE_DIV), .INIT_SPEED(INIT_SPEED)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  function automatic vec_t mk(input logic md, fa, sl, pa, input logic [3:0] led,
                              input logic [1:0] m, input logic [2:0] s,
                              input logic p, input logic st);
    vec_t v;
    v.md = md; v.fa = fa; v.sl = sl; v.pa = pa;
    v.led = led; v.mode = m; v.spd = s; v.paused = p; v.strobe = st;
    return v;
  endfunction

  task automatic check_out(input string name, input logic [3:0] led, input logic [1:0] m,
                           input logic [2:0] s, input logic p, input logic st);
    checks++;
    if (bus.led_out !== led || bus.mode !== m || bus.speed_lvl !== s ||
        bus.paused !== p || bus.step_strobe !== st) begin
      errors++;
      $display("FAIL %s: got led=%b mode=%0d spd=%0d paused=%b strobe=%b, expected led=%b mode=%0d spd=%0d paused=%b strobe=%b",
               name, bus.led_out, bus.mode, bus.speed_lvl, bus.paused, bus.step_strobe,
               led, m, s, p, st);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic run_tbl(input string name);
    foreach (tbl[i]) begin
      bus.btn_mode   = tbl[i].md;
      bus.btn_faster = tbl[i].fa;
      bus.btn_slower = tbl[i].sl;
      bus.btn_pause  = tbl[i].pa;
      tick();
      bus.btn_mode   = 1'b0;
      bus.btn_faster = 1'b0;
      bus.btn_slower = 1'b0;
      bus.btn_pause  = 1'b0;
      check_out($sformatf("%s[%0d]", name, i), tbl[i].led, tbl[i].mode, tbl[i].spd,
                tbl[i].paused, tbl[i].strobe);
    end
    tbl.delete();
  endtask

  // Waits for the next strobe; both the spacing and the new pattern are checked.
  task automatic step_check(input string name, input int exp_n, input logic [3:0] exp_led);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!bus.step_strobe && n < exp_n + 8);
    check_int({name, " spacing"}, n, exp_n);
    check_int({name, " led"}, int'(bus.led_out), int'(exp_led));
  endtask

  task automatic idle(input string name, input int n, input logic [3:0] exp_led);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (bus.step_strobe !== 1'b0 || bus.led_out !== exp_led) bad++;
    end
    check_int({name, " quiet cycles"}, bad, 0);
  endtask

  initial begin
    logic [3:0] bounce_exp [10];
    bounce_exp = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010,
                   4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100};

    bus.btn_mode   = 1'b1;
    bus.btn_faster = 1'b0;
    bus.btn_slower = 1'b0;
    bus.btn_pause  = 1'b0;
    tick();
    tick();
    check_out("reset", 4'b0001, 2'd0, 3'd3, 1'b0, 1'b0);
    bus.btn_mode = 1'b0;
    sys_rst      = 1'b0;

    step_check("shl1", 16, 4'b0010);
    step_check("shl2", 16, 4'b0100);
    step_check("shl3", 16, 4'b1000);
    step_check("shl4", 16, 4'b0001);

    tbl.push_back(mk(1, 0, 0, 0, 4'b1000, 2'd1, 3'd3, 0, 0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 0, 0, 4'b1000, 2'd1, 3'd3, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 4'b0001, 2'd2, 3'd3, 0, 0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 0, 0, 4'b0001, 2'd2, 3'd3, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 4'b1111, 2'd3, 3'd3, 0, 0));
    run_tbl("modes");

    step_check("blink0", 16, 4'b0000);
    step_check("blink1", 16, 4'b1111);

    tbl.push_back(mk(1, 0, 0, 0, 4'b0001, 2'd0, 3'd3, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 4'b1000, 2'd1, 3'd3, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 4'b0001, 2'd2, 3'd3, 0, 0));
    run_tbl("wrap");

    for (int i = 0; i < 10; i++)
      step_check($sformatf("bounce%0d", i), 16, bounce_exp[i]);

    tbl.push_back(mk(0, 1, 0, 0, 4'b0100, 2'd2, 3'd2, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 4'b0100, 2'd2, 3'd1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 4'b0100, 2'd2, 3'd0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 4'b0100, 2'd2, 3'd0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 4'b0100, 2'd2, 3'd0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 4'b0100, 2'd2, 3'd0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 4'b0010, 2'd2, 3'd0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 4'b0010, 2'd2, 3'd0, 0, 0));
    run_tbl("faster");
    step_check("spd0a", 3, 4'b0001);
    step_check("spd0b", 4, 4'b0010);

    for (int i = 1; i <= 7; i++)
      tbl.push_back(mk(0, 0, 1, 0, 4'b0010, 2'd2, 3'(i), 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 4'b0010, 2'd2, 3'd7, 0, 0));
    run_tbl("slower");
    step_check("spd7a", 31, 4'b0100);
    step_check("spd7b", 32, 4'b1000);

    tbl.push_back(mk(0, 1, 1, 0, 4'b1000, 2'd2, 3'd7, 0, 0));
    run_tbl("both");
    step_check("both_step", 31, 4'b0100);

    idle("pre_sup", 31, 4'b0100);
    tbl.push_back(mk(0, 1, 0, 0, 4'b0100, 2'd2, 3'd6, 0, 0));
    run_tbl("suppress");
    step_check("post_sup", 28, 4'b0010);

    idle("pre_pause", 22, 4'b0010);
    tbl.push_back(mk(0, 0, 0, 1, 4'b0010, 2'd2, 3'd6, 1, 0));
    run_tbl("pause_on");
    idle("paused", 19, 4'b0010);
    tbl.push_back(mk(0, 0, 0, 1, 4'b0010, 2'd2, 3'd6, 0, 0));
    run_tbl("pause_off");
    step_check("resume", 5, 4'b0001);

    tbl.push_back(mk(0, 0, 0, 1, 4'b0001, 2'd2, 3'd6, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 4'b1111, 2'd3, 3'd6, 1, 0));
    run_tbl("mode_paused");
    idle("held", 40, 4'b1111);
    tbl.push_back(mk(1, 0, 0, 1, 4'b0001, 2'd0, 3'd6, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 4'b1000, 2'd1, 3'd6, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 4'b0001, 2'd2, 3'd6, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 4'b1111, 2'd3, 3'd6, 0, 0));
    for (int i = 5; i >= 0; i--)
      tbl.push_back(mk(0, 1, 0, 0, 4'b1111, 2'd3, 3'(i), 0, 0));
    run_tbl("to_blink_fast");
    step_check("blink_fast", 4, 4'b0000);

    sys_rst        = 1'b1;
    bus.btn_slower = 1'b1;
    tick();
    check_out("mid_reset1", 4'b0001, 2'd0, 3'd3, 1'b0, 1'b0);
    tick();
    check_out("mid_reset2", 4'b0001, 2'd0, 3'd3, 1'b0, 1'b0);
    bus.btn_slower = 1'b0;
    sys_rst        = 1'b0;
    step_check("post_rst", 16, 4'b0010);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/led_mode_scheduler.md
# led_mode_scheduler

Sequencing controller for the 4-LED running-light datapath. It turns single-cycle button pulses into a mode, a speed level and a pause state, and derives its step timing from a prescaler. It drives the 4-bit LED vector directly, replacing the fixed-pattern free-running light with a user-configurable one. It sits between the button debouncers (pulse outputs) and the board LED pins.

## Interface
- BASE_DIV, 25: clock cycles per base tick; must be ≥ 2
- INIT_SPEED, 3: speed level loaded at reset (0..7)
- sys_clk  in  1  system clock
- sys_rst  in  1  synchronous, active-high reset
- btn_mode  in  1  one-cycle pulse; advance to next mode
- btn_faster  in  1  one-cycle pulse; decrement speed level
- btn_slower  in  1  one-cycle pulse; increment speed level
- btn_pause  in  1  one-cycle pulse; toggle pause
- led_out  out  4  LED pattern, registered
- mode  out  2  current mode: 0 SHIFT_L, 1 SHIFT_R, 2 BOUNCE, 3 BLINK
- speed_lvl  out  3  current speed level, 0 fastest
- paused  out  1  1 while stepping is frozen
- step_strobe  out  1  one-cycle pulse on the cycle led_out takes a step value

## Operation
- Prescaler `pre` counts 0..BASE_DIV-1 and wraps. base_tick = (pre == BASE_DIV-1) and not paused.
- Step counter `stp` counts base ticks 0..speed_lvl. A step occurs on base_tick when stp == speed_lvl; stp then returns to 0. Step period = BASE_DIV*(speed_lvl+1) cycles.
- While paused: pre, stp and led_out hold their values and no step occurs. On resume, counting continues from the held values.
- Mode FSM (on btn_mode): SHIFT_L→SHIFT_R→BOUNCE→BLINK→SHIFT_L. Entering a mode loads its initial pattern, clears pre and stp, and sets bounce direction to up. Pause state is unchanged.
- Patterns per step:
  - SHIFT_L: initial 0001, rotate left (1000→0001).
  - SHIFT_R: initial 1000, rotate right (0001→1000).
  - BOUNCE: initial 0001, direction up. Up shifts left and down shifts right. Direction flips on the step that lands on 1000 or on 0001. Sequence: 0001,0010,0100,1000,0100,0010,0001,0010…
  - BLINK: initial 1111, invert each step (1111↔0000).
- Speed: btn_faster decrements speed_lvl, saturating at 0. btn_slower increments it, saturating at 7. Any change in speed_lvl clears pre and stp. A saturated press (no change) has no effect on the counters.
- Same-cycle events, priority order:
  - btn_mode beats a same-cycle step. The pattern is reloaded and step_strobe stays 0.
  - btn_pause is applied together with btn_mode; both take effect.
  - btn_faster and btn_slower together leave speed_lvl unchanged.
  - A speed change in the same cycle as a would-be step suppresses that step.
- Reset (sys_rst=1 at an edge): led_out=0001, mode=0, speed_lvl=INIT_SPEED, paused=0, step_strobe=0, pre=0, stp=0, bounce direction up. Reset overrides all button inputs. Mid-operation reset returns to this state on the next edge.

## Timing
- All outputs are registered. A button pulse sampled at edge N is visible on mode, speed_lvl, paused and led_out (reload) after edge N.
- After reset is released with no presses, the first step is visible BASE_DIV*(INIT_SPEED+1) edges after the last reset edge. step_strobe is high for exactly that one cycle.
- Successive steps are exactly BASE_DIV*(speed_lvl+1) cycles apart while not paused and with no presses.
- After a mode or speed change at edge N, the next step occurs at edge N + BASE_DIV*(speed_lvl+1).
- A pause of P cycles delays all subsequent steps by exactly P cycles.

## Test plan
- Reset, BASE_DIV=4, INIT_SPEED=3, no presses → led_out 0001, then 0010, 0100, 1000, 0001 at 16-cycle spacing; one step_strobe per step.
- Three btn_mode pulses spaced 5 cycles apart → mode 1/1000, 2/0001, 3/1111. Then steps alternate 0000/1111 every 16 cycles. A fourth pulse → mode 0/0001.
- BOUNCE mode, 10 steps → 0010,0100,1000,0100,0010,0001,0010,0100,1000,0100.
- Eight btn_faster pulses → speed_lvl 0 (saturated), steps every 4 cycles. Eight btn_slower pulses → 7, steps every 32 cycles. faster+slower in the same cycle → unchanged.
- btn_pause 5 cycles before a step, held paused for 20 cycles, then btn_pause → step delayed by exactly 20 cycles. btn_mode while paused reloads the pattern and paused stays 1.
- sys_rst asserted mid-BLINK at speed 0 for 2 cycles → all outputs return to reset values, and the first step follows 16 cycles after release.
